sys_bus_ctrl: RTL
=================

SYS_BUS_CTRL -- requirements
Module: sys_bus_ctrl

Interface
REQ-001 SHALL have parameter NSLV, default 4: number of slave regions (2..16); SELW = clog2(NSLV).
REQ-002 SHALL have parameter REGION_SHIFT, default 12: bit position of the region index in the address.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before error (1..255).
REQ-004 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port m_req, input, 1: master access request, held until m_ready.
REQ-007 SHALL have port m_we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port m_addr, input, 32: byte address.
REQ-009 SHALL have port m_wdata, input, 32: write data.
REQ-010 SHALL have port m_rdata, output, 32: read data, valid while m_ready=1.
REQ-011 SHALL have port m_ready, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port m_err, output, 1: error flag, qualified by m_ready.
REQ-013 SHALL have port s_sel, output, NSLV: one-hot slave select.
REQ-014 SHALL have port s_we, output, 1: slave write strobe.
REQ-015 SHALL have port s_addr, output, 32: latched address, passed to all slaves unmodified.
REQ-016 SHALL have port s_wdata, output, 32: latched write data.
REQ-017 SHALL have port s_rdata, input, NSLV*32: slave k read data at bits [32k+31:32k].
REQ-018 SHALL have port s_ready, input, NSLV: per-slave completion.
REQ-019 SHALL have port err_count, output, 16: count of errored transactions.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-021 IDLE with m_req=1 SHALL latch m_addr, m_we and m_wdata on the clock edge; idx = latched_addr[REGION_SHIFT +: SELW].
REQ-022 Decode error SHALL be declared when idx >= NSLV or any latched_addr bit above REGION_SHIFT+SELW-1 is 1; on that edge IDLE goes directly to RESP with m_err=1, and no s_sel is asserted.
REQ-023 Valid decode SHALL go IDLE -> ACCESS.
REQ-024 In ACCESS, s_sel SHALL be one-hot at bit idx, and s_we SHALL equal the latched we; in all other states s_sel=0 and s_we=0.
REQ-025 In ACCESS, s_ready[idx]=1 SHALL go to RESP and register s_rdata[idx] into m_rdata (writes: m_rdata=0), with m_err=0; s_ready bits of unselected slaves SHALL be ignored.
REQ-026 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle; reaching TIMEOUT without s_ready[idx] SHALL go to RESP with m_err=1 and m_rdata=0.
REQ-027 If s_ready[idx] is asserted on the same cycle the timeout is reached, it SHALL complete as success (REQ-025), not as an error.
REQ-028 RESP SHALL last exactly one cycle with m_ready=1, then return to IDLE; m_req SHALL be ignored in RESP.
REQ-029 Minimum latency SHALL be: request edge t -> ACCESS cycle t+1 -> m_ready high in cycle t+2; back-to-back issue rate SHALL be one transaction per 3 cycles.
REQ-030 m_rdata and m_err SHALL hold their values until the next RESP.
REQ-031 err_count SHALL increment by 1 on each RESP with m_err=1 and saturate at 16'hFFFF.
REQ-032 m_req deasserted in IDLE SHALL produce no activity; latched registers SHALL change only on acceptance.

Reset
REQ-033 On reset=1, asynchronously: state=IDLE, s_sel=0, s_we=0, m_ready=0, m_err=0, m_rdata=0, err_count=0, wait counter=0, latched address/data=0.
REQ-034 Reset mid-ACCESS SHALL drop s_sel and s_we immediately, with no m_ready pulse for the aborted transaction.
REQ-035 The first accepted request SHALL be on the first rising edge with reset=0 and m_req=1.

Verification (NSLV=4, REGION_SHIFT=12, TIMEOUT=16)
REQ-036 Read 0x0000_2010; slave 2 ready in its first ACCESS cycle with data 0xCAFE_0002 -> s_sel=4'b0100 for 1 cycle, m_ready 2 cycles after request, m_rdata=0xCAFE_0002, m_err=0.
REQ-037 Write 0x0000_1004 with data 0x1234_5678; slave 1 ready after 3 wait cycles -> s_we=1, s_wdata=0x1234_5678 for 4 ACCESS cycles, then m_ready with m_err=0.
REQ-038 Read 0x0001_0000 -> no s_sel activity, m_ready 1 cycle after request, m_err=1, err_count=1.
REQ-039 Read 0x0000_3000 with slave 3 never ready -> 16 ACCESS cycles, then m_ready with m_err=1 and m_rdata=0; s_ready[3] on cycle 16 -> success instead.
REQ-040 Reset asserted during ACCESS -> s_sel=0 in the same cycle, no m_ready; after release a new read of 0x0000_0000 completes normally.
REQ-041 m_req held high continuously with slave 0 always ready -> m_ready every 3rd cycle, with s_sel never asserted during RESP.

Source files
------------

// File: rtl/sys_bus_ctrl.sv
// Single-master bus controller: decodes the region index from the address,
// selects one slave, waits for its ready or a timeout, and returns a one-cycle response.
module sys_bus_ctrl #(
  parameter int NSLV         = 4,
  parameter int REGION_SHIFT = 12,
  parameter int TIMEOUT      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_req,
  input  logic                 m_we,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  output logic [31:0]          m_rdata,
  output logic                 m_ready,
  output logic                 m_err,
  output logic [NSLV-1:0]      s_sel,
  output logic                 s_we,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  input  logic [NSLV*32-1:0]   s_rdata,
  input  logic [NSLV-1:0]      s_ready,
  output logic [15:0]          err_count,
  output logic [1:0]           dbg_state
);

  localparam int              SELW      = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int              TOPBIT    = REGION_SHIFT + SELW;
  localparam logic [63:0]     HI_MASK64 = ~((64'd1 << TOPBIT) - 64'd1);
  localparam logic [31:0]     HI_MASK   = HI_MASK64[31:0];
  localparam logic [SELW:0]   NSLV_EXT  = (SELW+1)'(NSLV);
  localparam logic [7:0]      TO_LAST   = 8'(TIMEOUT - 1);

  // Master handshake: m_req is held until the m_ready pulse; m_rdata/m_err are
  // valid while m_ready=1 and hold until the next response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, wdata_q;
  logic               we_q;
  logic [7:0]         wait_q;
  logic [SELW-1:0]    idx_in, idx_q;
  logic               dec_err_in;
  logic               accept, done_ok, done_to;
  logic [31:0]        sel_rdata;
  logic               sel_ready;

  assign idx_in     = m_addr[REGION_SHIFT +: SELW];
  assign idx_q      = addr_q[REGION_SHIFT +: SELW];
  // Decode is evaluated on the live address because it is the value latched on this edge.
  assign dec_err_in = ({1'b0, idx_in} >= NSLV_EXT) | (|(m_addr & HI_MASK));

  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_we      = (state_q == ACCESS) & we_q;
  assign m_ready   = (state_q == RESP);
  assign dbg_state = state_q;

  always_comb begin
    s_sel     = '0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == SELW'(k)) begin
        s_sel[k]  = (state_q == ACCESS);
        sel_rdata = s_rdata[32*k +: 32];
        sel_ready = s_ready[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          accept  = 1'b1;
          state_d = dec_err_in ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // Ready wins over a timeout landing on the same cycle.
        if (sel_ready) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (wait_q == TO_LAST) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      wait_q    <= '0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        addr_q  <= m_addr;
        wdata_q <= m_wdata;
        we_q    <= m_we;
        wait_q  <= '0;
        if (dec_err_in) begin
          m_rdata <= '0;
          m_err   <= 1'b1;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end else if (done_ok) begin
        m_rdata <= we_q ? 32'd0 : sel_rdata;
        m_err   <= 1'b0;
      end else if (done_to) begin
        m_rdata <= '0;
        m_err   <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (state_q == ACCESS) begin
        wait_q <= wait_q + 8'd1;
      end
    end
  end

endmodule
